lw_sha_round_ctrl: RTL and testbench
====================================

Name: lw_sha_round_ctrl

Overview:
Sequencer for the lightweight masked SHA-2 compression round datapath.
- Captures an initial masked working state, then drives the round datapath with the current state, round index, message word and 4 bits of fresh randomness.
- Registers the datapath's new state once per round and stops after 64 rounds (SHA-256) or 80 rounds (SHA-512).
- Sits between the message-schedule block, the RNG and the combinational round datapath.

Parameters:
WORD_W, 32, unmasked word width (32 or 64); each state lane is WORD_W+2 bits (2-bit rotation tag plus word).
S64, 0, 1 enables mode_i and 80-round operation; 0 forces SHA-256 behaviour and ignores mode_i.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start_i  in  1  start a compression; sampled in IDLE only
mode_i  in  1  0 = SHA-256 (64 rounds), 1 = SHA-512 (80 rounds); captured on start
init_state_i  in  8x(WORD_W+2)  masked initial state {a..h}; lane 7 = a; captured on start
busy_o  out  1  high in RUN and DONE
w_valid_i  in  1  message word available
w_data_i  in  WORD_W  message word W[t]
w_ready_o  out  1  word consumed this cycle
rnd_valid_i  in  1  random nibble available
rnd_i  in  4  random bits
rnd_ready_o  out  1  nibble consumed this cycle
rd_state_o  out  8x(WORD_W+2)  current state to round datapath
rd_word_o  out  WORD_W  word to round datapath (= w_data_i)
rd_random_o  out  4  random to round datapath (= rnd_i)
rd_round_o  out  7  round index to datapath
rd_mode_o  out  1  captured mode
rd_new_state_i  in  8x(WORD_W+2)  datapath result
done_o  out  1  final state valid
state_o  out  8x(WORD_W+2)  final masked state (= state register)
ack_i  in  1  consumer accepted result
abort_i  in  1  synchronous abort

Behaviour:
- Reset: FSM=IDLE, state regs=0, round counter=0, mode reg=0; busy_o, done_o, w_ready_o and rnd_ready_o all 0; rd_round_o=0.
- IDLE: when start_i=1, load the state regs from init_state_i and the mode reg from mode_i (forced to 0 if S64=0); set counter to 0; go to RUN next cycle.
- RUN: a round fires in any cycle where w_valid_i & rnd_valid_i = 1.
  - On fire: w_ready_o=rnd_ready_o=1 (combinational); state regs <= rd_new_state_i; counter increments.
  - Without a fire: ready outputs stay 0 and state and counter hold. Neither stream is consumed alone.
- Last round index is 63 for mode 0 and 79 for mode 1. Firing at the last index goes to DONE; the counter saturates at the last index and never wraps.
- rd_round_o = counter; rd_mode_o = mode reg.
- Minimum latency with both streams continuously valid: 64 or 80 RUN cycles after the start cycle; done_o asserts in the following cycle.
- DONE: done_o=1; state_o is stable; ready outputs are 0. On ack_i=1, go to IDLE and drop done_o next cycle. start_i is ignored in DONE.
- abort_i, any state: next state is IDLE, counter=0, state regs zeroed (no masked state is retained). abort_i has priority over start_i, fire and ack_i in the same cycle.
- start_i in RUN is ignored.
- Async reset mid-RUN clears everything immediately; no partial result is presented.

Optional Feature:
LW_SHA_DUMMY_ROUND_EN.
- Defined:
  - Adds input dummy_i (1 bit).
  - In RUN, a cycle with rnd_valid_i=1 and dummy_i=1 is a dummy round: rnd_ready_o=1 and randomness is consumed; w_ready_o=0; the datapath is fed state and word as normal but rd_new_state_i is discarded; counter unchanged.
  - At most 3 consecutive dummy rounds; after that, dummy_i is ignored until a real round fires.
- Undefined: no dummy_i port; behaviour exactly as above.

Test Plan:
- SHA-256 "abc" block: start with IV, mode 0, both streams always valid -> done_o at cycle 65 after start; state_o unmasked plus IV = ba7816bf...f20015ad.
- S64=1, mode 1, "abc" -> exactly 80 word handshakes, done_o at cycle 81, feed-forward gives ddaf35a1...a54ca49f.
- Stall pattern: w_valid_i toggling every cycle and rnd_valid_i low every 3rd cycle -> same digest as the unstalled run; handshake count exactly 64; no ready while either valid is low.
- abort_i asserted at round 30 together with a fire -> next cycle IDLE, state_o=0, busy_o=0; a fresh start then completes correctly.
- DONE held 10 cycles with ack_i=0 and start_i=1 -> state_o stable, done_o=1, no new start; ack_i=1 -> IDLE.
- LW_SHA_DUMMY_ROUND_EN with dummy_i held at 1 -> pattern of 3 dummies then 1 real round; digest unchanged; 64 word handshakes and 256 random handshakes.

Source files
------------

// File: rtl/lw_sha_round_ctrl.sv
// Round sequencer for the masked SHA-2 compression datapath: holds the working state and feeds one round per word/random handshake.
// Optional build macro LW_SHA_DUMMY_ROUND_EN adds dummy_i for randomness-only dummy rounds.
module lw_sha_round_ctrl #(
    parameter int WORD_W = 32,
    parameter bit S64    = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      mode_i,
    input  logic [8*(WORD_W+2)-1:0]   init_state_i,
    output logic                      busy_o,
    input  logic                      w_valid_i,
    input  logic [WORD_W-1:0]         w_data_i,
    output logic                      w_ready_o,
    input  logic                      rnd_valid_i,
    input  logic [3:0]                rnd_i,
    output logic                      rnd_ready_o,
    output logic [8*(WORD_W+2)-1:0]   rd_state_o,
    output logic [WORD_W-1:0]         rd_word_o,
    output logic [3:0]                rd_random_o,
    output logic [6:0]                rd_round_o,
    output logic                      rd_mode_o,
    input  logic [8*(WORD_W+2)-1:0]   rd_new_state_i,
    output logic                      done_o,
    output logic [8*(WORD_W+2)-1:0]   state_o,
    input  logic                      ack_i,
    input  logic                      abort_i,
`ifdef LW_SHA_DUMMY_ROUND_EN
    input  logic                      dummy_i,
`endif
    output logic [1:0]                dbg_state_o
);

    localparam int STATE_W = 8 * (WORD_W + 2);

    // Handshake: a word and a random nibble are consumed together in the cycle
    // where both valids are high in RUN; the ready outputs are combinational.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [6:0]         round_q, round_d;
    logic               mode_q, mode_d;
    logic [6:0]         last_round;
    logic               dummy_round;
    logic               fire;

`ifdef LW_SHA_DUMMY_ROUND_EN
    logic [1:0]         dummy_q, dummy_d;

    // After three back-to-back dummies a real round must fire before the next dummy.
    assign dummy_round = (fsm_q == RUN) && rnd_valid_i && dummy_i && (dummy_q != 2'd3);
`else
    assign dummy_round = 1'b0;
`endif

    assign last_round = mode_q ? 7'd79 : 7'd63;
    assign fire       = (fsm_q == RUN) && w_valid_i && rnd_valid_i && !dummy_round;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
`ifdef LW_SHA_DUMMY_ROUND_EN
            dummy_q <= '0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
            mode_q  <= mode_d;
`ifdef LW_SHA_DUMMY_ROUND_EN
            dummy_q <= dummy_d;
`endif
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        round_d     = round_q;
        mode_d      = mode_q;
        w_ready_o   = 1'b0;
        rnd_ready_o = 1'b0;
`ifdef LW_SHA_DUMMY_ROUND_EN
        dummy_d     = dummy_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    state_d = init_state_i;
                    mode_d  = S64 ? mode_i : 1'b0;
                    round_d = '0;
                    fsm_d   = RUN;
`ifdef LW_SHA_DUMMY_ROUND_EN
                    dummy_d = '0;
`endif
                end
            end
            RUN: begin
                if (dummy_round) begin
                    rnd_ready_o = 1'b1;
`ifdef LW_SHA_DUMMY_ROUND_EN
                    dummy_d     = dummy_q + 2'd1;
`endif
                end else if (fire) begin
                    w_ready_o   = 1'b1;
                    rnd_ready_o = 1'b1;
                    state_d     = rd_new_state_i;
`ifdef LW_SHA_DUMMY_ROUND_EN
                    dummy_d     = '0;
`endif
                    // The counter parks on the last index so it never wraps.
                    if (round_q == last_round) fsm_d = DONE;
                    else                       round_d = round_q + 7'd1;
                end
            end
            DONE: begin
                if (ack_i) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase

        // Abort wins over everything and wipes the masked state; nothing is consumed.
        if (abort_i) begin
            fsm_d       = IDLE;
            state_d     = '0;
            round_d     = '0;
            w_ready_o   = 1'b0;
            rnd_ready_o = 1'b0;
`ifdef LW_SHA_DUMMY_ROUND_EN
            dummy_d     = '0;
`endif
        end
    end

    assign busy_o      = (fsm_q != IDLE);
    assign done_o      = (fsm_q == DONE);
    assign state_o     = state_q;
    assign rd_state_o  = state_q;
    assign rd_word_o   = w_data_i;
    assign rd_random_o = rnd_i;
    assign rd_round_o  = round_q;
    assign rd_mode_o   = mode_q;
    assign dbg_state_o = fsm_q;

endmodule

// File: tb/tb_lw_sha_round_ctrl.sv
// Directed bench for lw_sha_round_ctrl: a reference SHA-256 round model closes the loop and the
// "abc" digest is checked; a second instance (S64=1) checks 80-round sequencing with a counting datapath.
module tb_lw_sha_round_ctrl;

    localparam int W  = 32;
    localparam int LW = W + 2;
    localparam int SW = 8 * LW;

    localparam logic [255:0] IV_VEC = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIGEST = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start_i = 1'b0, mode_i = 1'b0, ack_i = 1'b0, abort_i = 1'b0;
    logic [SW-1:0] init_state_i = '0;
    logic          w_valid_i = 1'b0, rnd_valid_i = 1'b0;
    logic [W-1:0]  w_data_i;
    logic [3:0]    rnd_i = 4'h0;
    logic          busy_o, w_ready_o, rnd_ready_o, rd_mode_o, done_o;
    logic [SW-1:0] rd_state_o, rd_new_state_i, state_o;
    logic [W-1:0]  rd_word_o;
    logic [3:0]    rd_random_o;
    logic [6:0]    rd_round_o;
    logic [1:0]    dbg_state_o;
`ifdef LW_SHA_DUMMY_ROUND_EN
    logic          dummy_i = 1'b0;
`endif

    logic          start2 = 1'b0, mode2 = 1'b0;
    logic [SW-1:0] init2 = '0;
    logic          busy2, w_ready2, rnd_ready2, rd_mode2, done2;
    logic [SW-1:0] rd_state2, rd_new_state2, state2;
    logic [W-1:0]  rd_word2;
    logic [3:0]    rd_random2;
    logic [6:0]    rd_round2;
    logic [1:0]    dbg_state2;

    lw_sha_round_ctrl #(.WORD_W(W), .S64(1'b0)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .init_state_i(init_state_i),
        .busy_o(busy_o), .w_valid_i(w_valid_i), .w_data_i(w_data_i), .w_ready_o(w_ready_o),
        .rnd_valid_i(rnd_valid_i), .rnd_i(rnd_i), .rnd_ready_o(rnd_ready_o),
        .rd_state_o(rd_state_o), .rd_word_o(rd_word_o), .rd_random_o(rd_random_o),
        .rd_round_o(rd_round_o), .rd_mode_o(rd_mode_o), .rd_new_state_i(rd_new_state_i),
        .done_o(done_o), .state_o(state_o), .ack_i(ack_i), .abort_i(abort_i),
`ifdef LW_SHA_DUMMY_ROUND_EN
        .dummy_i(dummy_i),
`endif
        .dbg_state_o(dbg_state_o)
    );

    lw_sha_round_ctrl #(.WORD_W(W), .S64(1'b1)) dut2 (
        .clk(clk), .rst(rst), .start_i(start2), .mode_i(mode2), .init_state_i(init2),
        .busy_o(busy2), .w_valid_i(w_valid_i), .w_data_i(w_data_i), .w_ready_o(w_ready2),
        .rnd_valid_i(rnd_valid_i), .rnd_i(rnd_i), .rnd_ready_o(rnd_ready2),
        .rd_state_o(rd_state2), .rd_word_o(rd_word2), .rd_random_o(rd_random2),
        .rd_round_o(rd_round2), .rd_mode_o(rd_mode2), .rd_new_state_i(rd_new_state2),
        .done_o(done2), .state_o(state2), .ack_i(ack_i), .abort_i(abort_i),
`ifdef LW_SHA_DUMMY_ROUND_EN
        .dummy_i(1'b0),
`endif
        .dbg_state_o(dbg_state2)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] digest(input logic [SW-1:0] s);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = s[i*LW +: 32] + IV_VEC[i*32 +: 32];
        return d;
    endfunction

    // Message schedule for the single padded block "abc".
    logic [31:0] w_sched [64];

    // Reference unmasked round datapath (tags held at zero).
    logic [31:0] dp_a, dp_b, dp_c, dp_d, dp_e, dp_f, dp_g, dp_h, dp_k, dp_t1, dp_t2;
    always_comb begin
        dp_a  = rd_state_o[7*LW +: 32];
        dp_b  = rd_state_o[6*LW +: 32];
        dp_c  = rd_state_o[5*LW +: 32];
        dp_d  = rd_state_o[4*LW +: 32];
        dp_e  = rd_state_o[3*LW +: 32];
        dp_f  = rd_state_o[2*LW +: 32];
        dp_g  = rd_state_o[1*LW +: 32];
        dp_h  = rd_state_o[0*LW +: 32];
        dp_k  = (rd_round_o < 7'd64) ? K_TAB[rd_round_o[5:0]] : 32'h0;
        dp_t1 = dp_h + (rotr(dp_e, 6) ^ rotr(dp_e, 11) ^ rotr(dp_e, 25))
              + ((dp_e & dp_f) ^ (~dp_e & dp_g)) + dp_k + rd_word_o;
        dp_t2 = (rotr(dp_a, 2) ^ rotr(dp_a, 13) ^ rotr(dp_a, 22))
              + ((dp_a & dp_b) ^ (dp_a & dp_c) ^ (dp_b & dp_c));
        rd_new_state_i = {2'b0, dp_t1 + dp_t2, 2'b0, dp_a, 2'b0, dp_b, 2'b0, dp_c,
                          2'b0, dp_d + dp_t1, 2'b0, dp_e, 2'b0, dp_f, 2'b0, dp_g};
    end

    assign rd_new_state2 = rd_state2 + SW'(1);

    int  w_hs = 0, r_hs = 0, w_hs2 = 0, bad_rdy = 0;
    logic clr_cnt = 1'b0;
    assign w_data_i = (w_hs < 64) ? w_sched[w_hs] : 32'h0;

    always @(posedge clk) begin
        if (clr_cnt) begin
            w_hs <= 0; r_hs <= 0; w_hs2 <= 0; bad_rdy <= 0;
        end else begin
            if (w_valid_i && w_ready_o)     w_hs  <= w_hs + 1;
            if (rnd_valid_i && rnd_ready_o) r_hs  <= r_hs + 1;
            if (w_valid_i && w_ready2)      w_hs2 <= w_hs2 + 1;
            if ((w_ready_o && !(w_valid_i && rnd_valid_i)) || (rnd_ready_o && !rnd_valid_i))
                bad_rdy <= bad_rdy + 1;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
    endtask

    // Starts dut, runs until done_o (bounded) and returns the cycle index where done_o was first seen.
    task automatic run_block(input bit stall, output int cyc);
        start_i = 1'b1;
        mode_i  = 1'b1;
        w_valid_i = 1'b1;
        rnd_valid_i = 1'b1;
        cyc = 0;
        do begin
            step();
            start_i = 1'b0;
            cyc++;
            if (cyc == 1) begin
                check("run_busy", SW'(busy_o), SW'(1));
                check("mode_forced_256", SW'(rd_mode_o), SW'(0));
            end
            if (!done_o && stall) begin
                w_valid_i   = (cyc % 2) == 1;
                rnd_valid_i = (cyc % 3) != 0;
            end
        end while (!done_o && cyc < 1000);
        check("done_reached", SW'(done_o), SW'(1));
    endtask

    task automatic ack_done();
        w_valid_i = 1'b0;
        rnd_valid_i = 1'b0;
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
    endtask

    logic [SW-1:0] iv_state;
    int cyc;
    int hold_bad;

    initial begin
        for (int t = 0; t < 16; t++) w_sched[t] = 32'h0;
        w_sched[0]  = 32'h61626380;
        w_sched[15] = 32'h00000018;
        for (int t = 16; t < 64; t++)
            w_sched[t] = (rotr(w_sched[t-2], 17) ^ rotr(w_sched[t-2], 19) ^ (w_sched[t-2] >> 10))
                       + w_sched[t-7]
                       + (rotr(w_sched[t-15], 7) ^ rotr(w_sched[t-15], 18) ^ (w_sched[t-15] >> 3))
                       + w_sched[t-16];
        for (int i = 0; i < 8; i++) iv_state[i*LW +: LW] = {2'b00, IV_VEC[i*32 +: 32]};

        // Reset state, with both valids high to show IDLE never consumes.
        w_valid_i = 1'b1;
        rnd_valid_i = 1'b1;
        rnd_i = 4'hA;
        repeat (2) step();
        rst = 1'b0;
        step();
        check("rst_fsm", SW'(dbg_state_o), SW'(0));
        check("rst_busy_done", SW'({busy_o, done_o}), SW'(0));
        check("rst_ready", SW'({w_ready_o, rnd_ready_o}), SW'(0));
        check("rst_state", state_o, '0);
        check("rst_round_mode", SW'({rd_round_o, rd_mode_o}), SW'(0));
        check("rnd_passthru", SW'(rd_random_o), SW'(4'hA));

        // SHA-256 "abc", both streams always valid.
        init_state_i = iv_state;
        clear_counts();
        run_block(1'b0, cyc);
        check("abc_latency", SW'(cyc), SW'(65));
        check("abc_digest", SW'(digest(state_o)), SW'(ABC_DIGEST));
        check("abc_w_hs", SW'(w_hs), SW'(64));
        check("done_no_ready", SW'({w_ready_o, rnd_ready_o}), SW'(0));
        check("done_round_sat", SW'(rd_round_o), SW'(63));

        // DONE hold: start ignored, state stable until ack.
        start_i = 1'b1;
        hold_bad = 0;
        repeat (10) begin
            step();
            if (!done_o || digest(state_o) !== ABC_DIGEST) hold_bad++;
        end
        check("done_hold", SW'(hold_bad), SW'(0));
        start_i = 1'b0;
        ack_done();
        check("ack_idle", SW'({busy_o, done_o, dbg_state_o}), SW'(0));
        step();
        check("ack_no_restart", SW'(busy_o), SW'(0));

        // Stalled streams produce the same digest with exactly 64 handshakes.
        clear_counts();
        run_block(1'b1, cyc);
        check("stall_digest", SW'(digest(state_o)), SW'(ABC_DIGEST));
        check("stall_w_hs", SW'(w_hs), SW'(64));
        check("stall_r_hs", SW'(r_hs), SW'(64));
        check("stall_ready_rule", SW'(bad_rdy), SW'(0));
        ack_done();

        // Abort at round 30 coinciding with a fire.
        start_i = 1'b1;
        w_valid_i = 1'b1;
        rnd_valid_i = 1'b1;
        cyc = 0;
        do begin
            step();
            start_i = 1'b0;
            cyc++;
        end while (rd_round_o != 7'd30 && cyc < 200);
        check("abort_reach_r30", SW'(rd_round_o), SW'(30));
        abort_i = 1'b1;
        #1;
        check("abort_no_ready", SW'({w_ready_o, rnd_ready_o}), SW'(0));
        step();
        abort_i = 1'b0;
        check("abort_idle", SW'({busy_o, done_o, dbg_state_o}), SW'(0));
        check("abort_state_zero", state_o, '0);
        check("abort_round_zero", SW'(rd_round_o), SW'(0));
        clear_counts();
        run_block(1'b0, cyc);
        check("post_abort_latency", SW'(cyc), SW'(65));
        check("post_abort_digest", SW'(digest(state_o)), SW'(ABC_DIGEST));
        ack_done();

        // Asynchronous reset in the middle of RUN.
        start_i = 1'b1;
        w_valid_i = 1'b1;
        rnd_valid_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (10) step();
        #2 rst = 1'b1;
        #1;
        check("areset_clear", SW'({busy_o, done_o, rd_round_o}), SW'(0));
        check("areset_state", state_o, '0);
        step();
        rst = 1'b0;
        w_valid_i = 1'b0;
        rnd_valid_i = 1'b0;
        step();

        // S64=1, mode 1: 80 rounds with a counting datapath.
        init2 = {8{34'h0_1234_5600}};
        clear_counts();
        start2 = 1'b1;
        mode2  = 1'b1;
        w_valid_i = 1'b1;
        rnd_valid_i = 1'b1;
        cyc = 0;
        do begin
            step();
            start2 = 1'b0;
            cyc++;
            if (cyc == 1) check("s64_mode", SW'(rd_mode2), SW'(1));
        end while (!done2 && cyc < 1000);
        check("s64_latency", SW'(cyc), SW'(81));
        check("s64_state", state2, init2 + SW'(80));
        check("s64_w_hs", SW'(w_hs2), SW'(80));
        check("s64_round_sat", SW'(rd_round2), SW'(79));
        ack_done();
        check("s64_ack_idle", SW'({busy2, done2}), SW'(0));

`ifdef LW_SHA_DUMMY_ROUND_EN
        // Dummy rounds: three dummies then one real round, digest unchanged.
        dummy_i = 1'b1;
        clear_counts();
        run_block(1'b0, cyc);
        check("dummy_latency", SW'(cyc), SW'(257));
        check("dummy_digest", SW'(digest(state_o)), SW'(ABC_DIGEST));
        check("dummy_w_hs", SW'(w_hs), SW'(64));
        check("dummy_r_hs", SW'(r_hs), SW'(256));
        dummy_i = 1'b0;
        ack_done();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
